// File: rtl/os_rx_ctrl.sv
// Receive-path sequencer for the dual-edge oversampler: bit recovery, preamble/SFD hunt,
// PHR length capture and PSDU byte streaming.
module os_rx_ctrl #(
  parameter int         OSR      = 2,
  parameter int         PRE_BITS = 32,
  parameter logic [7:0] SFD      = 8'hA7,
  parameter int         SFD_WIN  = 16,
  parameter int         TIMEOUT  = 1023
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_START,
  input  logic       i_ABORT,
  input  logic       i_QLE,
  input  logic       i_QTE,
  output logic       o_OS_EN,
  output logic       o_BUSY,
  output logic       o_SFD_DET,
  output logic [6:0] o_LEN,
  output logic [7:0] o_BYTE,
  output logic       o_BYTE_VALID,
  output logic       o_DONE,
  output logic       o_ERR
);

  localparam int PH_W  = (OSR > 2) ? $clog2(OSR) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + SFD_WIN + 2 * OSR + 8);
  localparam int ZC_W  = $clog2(PRE_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WARM, S_PRE, S_SFD, S_PHR, S_PSDU, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic              qle_q, qle_d;
  logic [ZC_W-1:0]   zcnt_q, zcnt_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [7:0]        sr_q, sr_d;
  logic [6:0]        bytes_q, bytes_d;
  logic [6:0]        len_q, len_d;
  logic [7:0]        byte_q, byte_d;
  logic              os_en_q, os_en_d;
  logic              busy_q, busy_d;
  logic              sfd_det_q, sfd_det_d;
  logic              bv_q, bv_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              active;
  logic              edge_det;
  logic              strobe;
  logic [7:0]        sr_nx;

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    qle_d     = i_QLE;
    zcnt_d    = zcnt_q;
    bcnt_d    = bcnt_q;
    sr_d      = sr_q;
    bytes_d   = bytes_q;
    len_d     = len_q;
    byte_d    = byte_q;
    sfd_det_d = 1'b0;
    bv_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    active   = (state_q inside {S_PRE, S_SFD, S_PHR, S_PSDU});
    edge_det = i_QLE ^ qle_q;
    // An edge cycle is the first cycle of a new bit, so it can never be the mid-bit strobe.
    strobe   = active && !edge_det && (ph_q == PH_W'(OSR / 2));
    sr_nx    = {i_QTE, sr_q[7:1]};

    if (active) begin
      if (edge_det)
        ph_d = PH_W'(1);
      else
        ph_d = (ph_q == PH_W'(OSR - 1)) ? '0 : ph_q + PH_W'(1);
    end
    if (strobe) sr_d = sr_nx;

    case (state_q)
      S_IDLE: begin
        if (i_START) begin
          state_d = S_WARM;
          len_d   = '0;
          bcnt_d  = '0;
          sr_d    = '0;
        end
      end
      S_WARM: begin
        if (bcnt_q == CNT_W'(2 * OSR - 1)) begin
          state_d = S_PRE;
          bcnt_d  = '0;
          zcnt_d  = '0;
          ph_d    = '0;
        end else begin
          bcnt_d = bcnt_q + CNT_W'(1);
        end
      end
      S_PRE: begin
        if (strobe) begin
          zcnt_d = i_QTE ? '0 : zcnt_q + ZC_W'(1);
          if (!i_QTE && zcnt_q == ZC_W'(PRE_BITS - 1)) begin
            state_d = S_SFD;
            bcnt_d  = '0;
          end else if (bcnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end
      end
      S_SFD: begin
        if (strobe) begin
          if (sr_nx == SFD) begin
            state_d   = S_PHR;
            sfd_det_d = 1'b1;
            bcnt_d    = '0;
          end else if (bcnt_q == CNT_W'(SFD_WIN - 1)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end
      end
      S_PHR: begin
        if (strobe) begin
          if (bcnt_q == CNT_W'(7)) begin
            len_d  = sr_nx[6:0];
            bcnt_d = '0;
            if (sr_nx[6:0] == 7'd0) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_PSDU;
              bytes_d = sr_nx[6:0];
            end
          end else begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end
      end
      S_PSDU: begin
        if (strobe) begin
          if (bcnt_q == CNT_W'(7)) begin
            byte_d  = sr_nx;
            bv_d    = 1'b1;
            bcnt_d  = '0;
            bytes_d = bytes_q - 7'd1;
            if (bytes_q == 7'd1) state_d = S_DONE;
          end else begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort silently drops the frame: no status pulse and the partial byte/length never lands.
    if (i_ABORT && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      sfd_det_d = 1'b0;
      bv_d      = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      byte_d    = byte_q;
      len_d     = len_q;
    end

    busy_d  = (state_d != S_IDLE);
    os_en_d = busy_d;
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      qle_q     <= 1'b0;
      zcnt_q    <= '0;
      bcnt_q    <= '0;
      sr_q      <= '0;
      bytes_q   <= '0;
      len_q     <= '0;
      byte_q    <= '0;
      os_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      sfd_det_q <= 1'b0;
      bv_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      qle_q     <= qle_d;
      zcnt_q    <= zcnt_d;
      bcnt_q    <= bcnt_d;
      sr_q      <= sr_d;
      bytes_q   <= bytes_d;
      len_q     <= len_d;
      byte_q    <= byte_d;
      os_en_q   <= os_en_d;
      busy_q    <= busy_d;
      sfd_det_q <= sfd_det_d;
      bv_q      <= bv_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_OS_EN      = os_en_q;
  assign o_BUSY       = busy_q;
  assign o_SFD_DET    = sfd_det_q;
  assign o_LEN        = len_q;
  assign o_BYTE       = byte_q;
  assign o_BYTE_VALID = bv_q;
  assign o_DONE       = done_q;
  assign o_ERR        = err_q;

endmodule

// File: tb/tb_os_rx_ctrl.sv
// Directed frame-level bench for os_rx_ctrl: a table of frames with hand-computed event
// timings (relative to the START sample edge) plus hand-written corner-case sequences.
module tb_os_rx_ctrl;

  logic       i_CLK = 1'b0;
  logic       i_RST, i_START, i_ABORT, i_QLE, i_QTE;
  logic       o_OS_EN, o_BUSY, o_SFD_DET;
  logic [6:0] o_LEN;
  logic [7:0] o_BYTE;
  logic       o_BYTE_VALID, o_DONE, o_ERR;

  os_rx_ctrl dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_START(i_START), .i_ABORT(i_ABORT),
    .i_QLE(i_QLE), .i_QTE(i_QTE), .o_OS_EN(o_OS_EN), .o_BUSY(o_BUSY),
    .o_SFD_DET(o_SFD_DET), .o_LEN(o_LEN), .o_BYTE(o_BYTE),
    .o_BYTE_VALID(o_BYTE_VALID), .o_DONE(o_DONE), .o_ERR(o_ERR)
  );

  always #5 i_CLK = ~i_CLK;

  int cyc = 0;
  always @(posedge i_CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int   s_cyc = 0;
  logic mon_clr = 1'b0;
  int   sfd_cnt = 0, sfd_rel = 0, done_cnt = 0, done_rel = 0, err_cnt = 0, err_rel = 0, nbv = 0;
  logic [7:0] mb [8];
  int         mrel [8];

  always @(negedge i_CLK) begin
    if (mon_clr) begin
      sfd_cnt  <= 0; sfd_rel  <= 0;
      done_cnt <= 0; done_rel <= 0;
      err_cnt  <= 0; err_rel  <= 0;
      nbv      <= 0;
    end else begin
      if (o_SFD_DET) begin sfd_cnt <= sfd_cnt + 1; sfd_rel <= cyc - s_cyc; end
      if (o_DONE)    begin done_cnt <= done_cnt + 1; done_rel <= cyc - s_cyc; end
      if (o_ERR)     begin err_cnt <= err_cnt + 1; err_rel <= cyc - s_cyc; end
      if (o_BYTE_VALID) begin
        if (nbv < 8) begin
          mb[nbv]   <= o_BYTE;
          mrel[nbv] <= cyc - s_cyc;
        end
        nbv <= nbv + 1;
      end
    end
  end

  typedef struct {
    int         pre;
    bit         brk;
    logic [7:0] sfd;
    logic [7:0] phr;
    int         nd;
    logic [7:0] d0, d1, d2;
    int         shift;
    int         abort_rel;
    int         e_sfd, e_sfd_rel;
    int         e_len;
    int         e_nbv, e_bv_rel;
    int         e_done, e_done_rel;
    int         e_err, e_err_rel;
  } row_t;

  row_t rows [6];
  bit   bq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic do_start();
    mon_clr = 1'b1;
    @(negedge i_CLK);
    #1 mon_clr = 1'b0;
    tick();
    i_START = 1'b1;
    tick();
    i_START = 1'b0;
    s_cyc   = cyc;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int b = 0; b < 8; b++) bq.push_back(v[b]);
  endtask

  task automatic build(input row_t rw);
    bq.delete();
    for (int i = 0; i < rw.pre; i++) bq.push_back(1'b0);
    if (rw.brk) begin
      bq.push_back(1'b1);
      for (int i = 0; i < 32; i++) bq.push_back(1'b0);
    end
    push_byte(rw.sfd);
    push_byte(rw.phr);
    if (rw.nd > 0) push_byte(rw.d0);
    if (rw.nd > 1) push_byte(rw.d1);
    if (rw.nd > 2) push_byte(rw.d2);
  endtask

  // Bit k of bq is held on both OS outputs for 2 cycles starting at rel 4+shift (PRE entry).
  task automatic drive(input int ncyc, input int shift, input int abort_rel, input int rst_rel);
    int   k;
    logic b;
    for (int r = 0; r < ncyc; r++) begin
      if (r == 0) begin
        chk("busy_rise", o_BUSY, 1);
        chk("os_en_rise", o_OS_EN, 1);
        chk("len_clear", o_LEN, 0);
      end
      if (abort_rel != 0 && r == abort_rel + 1) begin
        chk("abort_busy", o_BUSY, 0);
        chk("abort_os_en", o_OS_EN, 0);
      end
      if (rst_rel != 0 && r == rst_rel + 1) i_RST = 1'b1;
      b = 1'b0;
      if (r >= 4 + shift) begin
        k = (r - 4 - shift) / 2;
        if (k < bq.size()) b = bq[k];
      end
      i_QLE   = b;
      i_QTE   = b;
      i_ABORT = (abort_rel != 0 && r == abort_rel);
      if (rst_rel != 0 && r == rst_rel) begin
        #1 i_RST = 1'b0;
        #1;
        chk("rst_busy", o_BUSY, 0);
        chk("rst_os_en", o_OS_EN, 0);
        chk("rst_len", o_LEN, 0);
        chk("rst_byte", o_BYTE, 0);
        chk("rst_bv", o_BYTE_VALID, 0);
      end
      tick();
    end
    i_QLE   = 1'b0;
    i_QTE   = 1'b0;
    i_ABORT = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] db [3];

    //            pre brk  sfd    phr    nd d0     d1     d2    sh abort sfd@   len nbv bv@  done@   err@
    rows[0] = '{32, 1'b0, 8'hA7, 8'h03, 3, 8'h11, 8'h22, 8'h33, 0, 0,   1, 84,  3, 3, 116, 1, 149, 0, 0};
    rows[1] = '{20, 1'b1, 8'hA7, 8'h01, 1, 8'h5A, 8'h00, 8'h00, 0, 0,   1, 126, 1, 1, 158, 1, 159, 0, 0};
    rows[2] = '{32, 1'b0, 8'hA7, 8'h03, 3, 8'h11, 8'h22, 8'h33, 0, 120, 1, 84,  3, 1, 116, 0, 0,   0, 0};
    rows[3] = '{32, 1'b0, 8'hA7, 8'h80, 0, 8'h00, 8'h00, 8'h00, 0, 0,   1, 84,  0, 0, 0,   0, 0,   1, 100};
    rows[4] = '{32, 1'b0, 8'h55, 8'h55, 0, 8'h00, 8'h00, 8'h00, 0, 0,   0, 0,   0, 0, 0,   0, 0,   1, 100};
    rows[5] = '{32, 1'b0, 8'hA7, 8'h03, 3, 8'h11, 8'h22, 8'h33, 1, 0,   1, 85,  3, 3, 117, 1, 150, 0, 0};

    i_RST = 1'b0; i_START = 1'b0; i_ABORT = 1'b0; i_QLE = 1'b0; i_QTE = 1'b0;
    #12;
    chk("reset_os_en", o_OS_EN, 0);
    chk("reset_busy", o_BUSY, 0);
    chk("reset_sfd", o_SFD_DET, 0);
    chk("reset_len", o_LEN, 0);
    chk("reset_byte", o_BYTE, 0);
    chk("reset_bv", o_BYTE_VALID, 0);
    chk("reset_done", o_DONE, 0);
    chk("reset_err", o_ERR, 0);
    @(posedge i_CLK);
    #1 i_RST = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      build(rows[i]);
      do_start();
      drive(4 + rows[i].shift + 2 * bq.size() + 12, rows[i].shift, rows[i].abort_rel, 0);
      db[0] = rows[i].d0; db[1] = rows[i].d1; db[2] = rows[i].d2;
      chk($sformatf("r%0d_sfd_cnt", i), sfd_cnt, rows[i].e_sfd);
      if (rows[i].e_sfd != 0) chk($sformatf("r%0d_sfd_rel", i), sfd_rel, rows[i].e_sfd_rel);
      chk($sformatf("r%0d_len", i), o_LEN, rows[i].e_len);
      chk($sformatf("r%0d_nbv", i), nbv, rows[i].e_nbv);
      for (int j = 0; j < rows[i].e_nbv && j < 3; j++) begin
        chk($sformatf("r%0d_byte%0d", i, j), mb[j], db[j]);
        chk($sformatf("r%0d_byte%0d_rel", i, j), mrel[j], rows[i].e_bv_rel + 16 * j);
      end
      chk($sformatf("r%0d_done_cnt", i), done_cnt, rows[i].e_done);
      if (rows[i].e_done != 0) chk($sformatf("r%0d_done_rel", i), done_rel, rows[i].e_done_rel);
      chk($sformatf("r%0d_err_cnt", i), err_cnt, rows[i].e_err);
      if (rows[i].e_err != 0) chk($sformatf("r%0d_err_rel", i), err_rel, rows[i].e_err_rel);
      chk($sformatf("r%0d_busy_end", i), o_BUSY, 0);
      chk($sformatf("r%0d_os_en_end", i), o_OS_EN, 0);
    end

    // START and ABORT together in IDLE: START wins; a later lone ABORT ends the frame quietly.
    mon_clr = 1'b1;
    @(negedge i_CLK);
    #1 mon_clr = 1'b0;
    tick();
    i_START = 1'b1; i_ABORT = 1'b1;
    tick();
    i_START = 1'b0; i_ABORT = 1'b0;
    chk("start_wins_busy", o_BUSY, 1);
    tick(); tick();
    i_ABORT = 1'b1;
    tick();
    i_ABORT = 1'b0;
    chk("idle_abort_busy", o_BUSY, 0);
    chk("idle_abort_os_en", o_OS_EN, 0);
    tick(); tick();
    chk("idle_abort_no_err", err_cnt, 0);
    chk("idle_abort_no_done", done_cnt, 0);

    // Line stuck at one: preamble hunt times out after 1023 strobes, then immediate re-arm.
    do_start();
    for (int r = 0; r <= 2050; r++) begin
      i_QLE = 1'b1; i_QTE = 1'b1;
      tick();
    end
    chk("timeout_err_cnt", err_cnt, 1);
    chk("timeout_err_rel", err_rel, 2050);
    chk("timeout_sfd_cnt", sfd_cnt, 0);
    chk("timeout_busy_low", o_BUSY, 0);
    i_START = 1'b1;
    tick();
    i_START = 1'b0;
    chk("b2b_start_busy", o_BUSY, 1);
    i_ABORT = 1'b1;
    tick();
    i_ABORT = 1'b0; i_QLE = 1'b0; i_QTE = 1'b0;
    chk("b2b_abort_busy", o_BUSY, 0);
    tick();

    // Asynchronous reset landing on the first byte strobe cycle.
    build(rows[0]);
    do_start();
    drive(160, 0, 0, 116);
    chk("midrst_sfd_cnt", sfd_cnt, 1);
    chk("midrst_nbv", nbv, 0);
    chk("midrst_done", done_cnt, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_busy", o_BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
